conv_frame_sequencer: RTL and testbench

CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

---
 rtl/conv_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - raster read-address sequencer for a pipelined frame filter
module conv_frame_sequencer #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int PIPE_LATENCY = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_req,
  input  logic                 ready,
  output logic [ADDR_BITS-1:0] rdaddress,
  output logic                 rden,
  output logic                 pix_valid,
  output logic                 sof,
  output logic                 eof,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           frame_count
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW   = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [CW-1:0]        COL_LAST  = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0]        ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(NPIX - 1);
  localparam logic [3:0]           DRAIN_END = 4'(PIPE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [ADDR_BITS-1:0] addr;
  logic                 last_issued;
  logic                 pending;
  logic [3:0]           drain_cnt;
  logic [2:0]           pipe [PIPE_LATENCY];

  logic last_pos;
  assign last_pos = (col == COL_LAST) && (row == ROW_LAST);

  // Frame FSM: issues one raster address per ready cycle, then waits out the filter latency
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      addr        <= '0;
      last_issued <= 1'b0;
      pending     <= 1'b0;
      drain_cnt   <= '0;
      rdaddress   <= '0;
      rden        <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      rden       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_req) begin
            state       <= SCAN;
            busy        <= 1'b1;
            rdaddress   <= '0;
            col         <= '0;
            row         <= '0;
            addr        <= '0;
            last_issued <= 1'b0;
            pending     <= 1'b0;
          end
        end
        SCAN: begin
          if (frame_req) pending <= 1'b1;
          if (last_issued) begin
            // last address was shown on rden during this cycle; start draining
            state     <= DRAIN;
            drain_cnt <= '0;
          end else if (ready) begin
            rden      <= 1'b1;
            rdaddress <= addr;
            if (last_pos) begin
              last_issued <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (frame_req) pending <= 1'b1;
          if (drain_cnt == DRAIN_END) begin
            state       <= DONE;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          // a request arriving in this very cycle is honoured like a pending one
          if (pending || frame_req) begin
            state       <= SCAN;
            rdaddress   <= '0;
            col         <= '0;
            row         <= '0;
            addr        <= '0;
            last_issued <= 1'b0;
            pending     <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Delay line of {valid, first, last} matching the filter latency; runs every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PIPE_LATENCY; k++) pipe[k] <= 3'b000;
    end else begin
      for (int k = PIPE_LATENCY - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= {rden, rden && (rdaddress == '0), rden && (rdaddress == ADDR_LAST)};
    end
  end

  assign pix_valid = pipe[PIPE_LATENCY-1][2];
  assign sof       = pipe[PIPE_LATENCY-1][1];
  assign eof       = pipe[PIPE_LATENCY-1][0];

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - randomized self-checking bench for conv_frame_sequencer
module tb_conv_frame_sequencer;

  localparam int W    = 5;
  localparam int H    = 3;
  localparam int PL   = 4;
  localparam int AB   = 4;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          rdy;
  logic [AB-1:0] rdaddress;
  logic          rden, pix_valid, sof, eof, busy, frame_done;
  logic [7:0]    frame_count;

  conv_frame_sequencer #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .ADDR_BITS   (AB),
    .PIPE_LATENCY(PL)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .frame_req  (req),
    .ready      (rdy),
    .rdaddress  (rdaddress),
    .rden       (rden),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .eof        (eof),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- behavioural reference ----------------
  // phase: 0 waiting for request, 1 issuing pixels, 2 waiting latency, 3 completion cycle
  int         ph = 0;
  int         issued = 0;
  int         dleft = 0;
  bit         pend = 0;
  int         fc = 0;
  bit         m_busy = 0, m_done = 0, m_rden = 0;
  int         m_addr = 0;
  bit         h_rden [64];
  int         h_addr [64];
  int         mc = 100;
  bit         e_pix = 0, e_sof = 0, e_eof = 0;

  always @(posedge clk) begin
    int idx;
    mc++;
    if (rst) begin
      ph = 0; issued = 0; dleft = 0; pend = 0; fc = 0;
      m_busy = 0; m_done = 0; m_rden = 0; m_addr = 0;
      for (int i = 0; i < 64; i++) begin h_rden[i] = 0; h_addr[i] = 0; end
    end else begin
      m_rden = 0;
      m_done = 0;
      case (ph)
        0: if (req) begin ph = 1; issued = 0; m_addr = 0; pend = 0; m_busy = 1; end
        1: begin
          if (req) pend = 1;
          if (issued == NPIX) begin ph = 2; dleft = PL; end
          else if (rdy) begin m_rden = 1; m_addr = issued; issued++; end
        end
        2: begin
          if (req) pend = 1;
          dleft--;
          if (dleft == 0) begin ph = 3; m_done = 1; fc = (fc + 1) % 256; end
        end
        default: begin
          if (pend || req) begin ph = 1; issued = 0; m_addr = 0; pend = 0; end
          else begin ph = 0; m_busy = 0; end
        end
      endcase
    end
    h_rden[mc % 64] = m_rden;
    h_addr[mc % 64] = m_addr;
    idx   = (mc - PL) % 64;
    e_pix = h_rden[idx];
    e_sof = e_pix && (h_addr[idx] == 0);
    e_eof = e_pix && (h_addr[idx] == NPIX - 1);
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  int pv_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_outputs",
            {rdaddress, rden, pix_valid, sof, eof, busy, frame_done, frame_count},
            {AB'(m_addr), m_rden, e_pix, e_sof, e_eof, m_busy, m_done, 8'(fc)});
      if (frame_done) begin
        check("pix_per_frame", pv_cnt, NPIX);
        pv_cnt = 0;
      end else if (pix_valid) begin
        pv_cnt++;
      end else if (!busy) begin
        pv_cnt = 0;
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check(name, busy, 0);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_rden, sof_at, eof_at, done_at, n_rden, busy_low, dones, n_pv;
    bit hit;
    rst = 1'b1; req = 1'b0; rdy = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    check("reset_busy", busy, 0);
    check("reset_count", frame_count, 0);
    check("reset_rden", rden, 0);
    check("reset_pix", pix_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed frame, ready held high: pin absolute latencies
    rdy = 1'b1;
    first_rden = -1; sof_at = -1; eof_at = -1; done_at = -1;
    @(negedge clk);
    req = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) req = 1'b0;
      if (rden && first_rden < 0) first_rden = i;
      if (sof && sof_at < 0) sof_at = i;
      if (eof && eof_at < 0) eof_at = i;
      if (frame_done && done_at < 0) done_at = i;
    end
    check("first_rden_cycle", first_rden, 2);
    check("sof_cycle", sof_at, 6);
    check("eof_cycle", eof_at, 20);
    check("frame_done_cycle", done_at, 21);
    check("count_after_frame1", frame_count, 1);

    // ready toggling every cycle
    n_rden = 0;
    pulse_req();
    for (int i = 0; i < 200 && busy; i++) begin
      rdy = i[0];
      @(negedge clk);
      if (rden) n_rden++;
    end
    rdy = 1'b1;
    wait_idle(100, "toggle_frame_timeout");
    check("toggle_rden_count", n_rden, NPIX);
    check("count_after_toggle", frame_count, 2);

    // two requests during scan: exactly one back-to-back extra frame
    busy_low = 0;
    pulse_req();
    repeat (3) @(negedge clk);
    req = 1'b1; @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);
    req = 1'b1; @(negedge clk); req = 1'b0;
    for (int i = 0; i < 500 && frame_count != 8'd4; i++) begin
      rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!busy) busy_low++;
    end
    rdy = 1'b1;
    check("busy_gap_between_frames", busy_low, 0);
    wait_idle(100, "double_req_timeout");
    repeat (10) @(negedge clk);
    check("count_after_double_req", frame_count, 4);
    check("no_third_frame", busy, 0);

    // abort mid-frame at address 7, reset coinciding with a request
    pulse_req();
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (rden && rdaddress == AB'(7)) hit = 1;
    end
    check("reached_addr7", hit, 1);
    rst = 1'b1; req = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    check("abort_outputs_zero",
          {rdaddress, rden, pix_valid, sof, eof, busy, frame_done, frame_count}, 0);
    dones = 0; n_pv = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done) dones++;
      if (pix_valid) n_pv++;
    end
    check("abort_no_done", dones, 0);
    check("abort_no_pix", n_pv, 0);

    // random traffic until 256 completed frames wrap the counter
    dones = 0;
    for (int i = 0; i < 40000 && dones < 256; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      req = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (frame_done) begin
        dones++;
        if (dones == 256) check("count_wrap", frame_count, 0);
      end
    end
    req = 1'b0;
    check("random_frames_done", dones, 256);
    rdy = 1'b1;
    wait_idle(200, "final_idle_timeout");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
